prod_accumulator: RTL and testbench

//  Downstream consumer of the unsigned multiplier product stream. Sums N successive products
//  (or fewer, if closed early by p_last) into one dot-product result. Presents the result on
//  a valid/ready output port. Sits between the multiplier and any result sink or bench.

---
 rtl/prod_accumulator.sv | 96 +++++++++
 tb/tb_prod_accumulator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prod_accumulator.sv
// Sums up to N unsigned product beats into one result.
// A group closes after N beats or on p_last; the result is then held on a valid/ready port.
module prod_accumulator #(
  parameter  int PW = 8,
  parameter  int N  = 4,
  parameter  int AW = 10,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          p_valid,
  input  logic [PW-1:0] p_data,
  input  logic          p_last,
  output logic          p_ready,
  output logic          acc_valid,
  output logic [AW-1:0] acc_data,
  output logic [CW-1:0] acc_terms,
  output logic          acc_ovf,
  input  logic          acc_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic          accept;
  logic [AW:0]   sum_ext;
  logic [CW-1:0] cnt_inc;

  // p_ready is a function of state only, so a producer may wait on it without
  // creating a combinational loop through p_valid.
  assign p_ready = (state_q != HOLD) && !reset;
  assign accept  = p_valid && p_ready;

  assign sum_ext = {1'b0, acc_q} + (AW + 1)'(p_data);
  assign cnt_inc = cnt_q + CW'(1);

  // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = AW'(p_data);
          cnt_d   = CW'(1);
          ovf_d   = 1'b0;
          state_d = (N == 1 || p_last) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d   = sum_ext[AW-1:0];
          cnt_d   = cnt_inc;
          ovf_d   = ovf_q | sum_ext[AW];
          state_d = (cnt_inc == CW'(N) || p_last) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (acc_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result registers double as the accumulator; they are only advertised while in HOLD.
  assign acc_valid = (state_q == HOLD);
  assign acc_data  = acc_q;
  assign acc_terms = cnt_q;
  assign acc_ovf   = ovf_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Bench for prod_accumulator: default instance (AW=10,N=4) and a narrow one (AW=8,N=2),
// both compared every cycle against a group-level arithmetic model.
module tb_prod_accumulator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: PW=8, N=4, AW=10
  logic       pv_a, pl_a, pr_a, av_a, ao_a, ar_a;
  logic [7:0] pd_a;
  logic [9:0] ad_a;
  logic [2:0] at_a;
  // Instance B: PW=8, N=2, AW=8
  logic       pv_b, pl_b, pr_b, av_b, ao_b, ar_b;
  logic [7:0] pd_b;
  logic [7:0] ad_b;
  logic [1:0] at_b;

  prod_accumulator #(.PW(8), .N(4), .AW(10)) dut_a (
    .clock(clk), .reset(reset),
    .p_valid(pv_a), .p_data(pd_a), .p_last(pl_a), .p_ready(pr_a),
    .acc_valid(av_a), .acc_data(ad_a), .acc_terms(at_a), .acc_ovf(ao_a), .acc_ready(ar_a)
  );

  prod_accumulator #(.PW(8), .N(2), .AW(8)) dut_b (
    .clock(clk), .reset(reset),
    .p_valid(pv_b), .p_data(pd_b), .p_last(pl_b), .p_ready(pr_b),
    .acc_valid(av_b), .acc_data(ad_b), .acc_terms(at_b), .acc_ovf(ao_b), .acc_ready(ar_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: true running sum of the open group plus the held result.
  int unsigned nn[2]   = '{4, 2};
  int unsigned aw[2]   = '{10, 8};
  int unsigned g_sum[2], g_cnt[2], r_sum[2], r_cnt[2];
  bit          pending[2], took[2];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      g_sum[i] = 0; g_cnt[i] = 0; r_sum[i] = 0; r_cnt[i] = 0;
      pending[i] = 0; took[i] = 0;
    end
  endtask

  task automatic model_edge(int i, bit pv, int unsigned pd, bit pl, bit ar);
    took[i] = 0;
    if (pending[i]) begin
      if (ar) pending[i] = 0;
    end else if (pv) begin
      took[i] = 1;
      g_sum[i] += pd;
      g_cnt[i]++;
      if (g_cnt[i] == nn[i] || pl) begin
        r_sum[i]   = g_sum[i];
        r_cnt[i]   = g_cnt[i];
        pending[i] = 1;
        g_sum[i]   = 0;
        g_cnt[i]   = 0;
      end
    end
  endtask

  function automatic int unsigned exp_data(int i);
    return r_sum[i] % (32'd1 << aw[i]);
  endfunction

  function automatic bit exp_ovf(int i);
    return r_sum[i] >= (32'd1 << aw[i]);
  endfunction

  task automatic check_outputs();
    check("a_p_ready", pr_a, !pending[0]);
    check("a_acc_valid", av_a, pending[0]);
    if (pending[0]) begin
      check("a_acc_data", ad_a, exp_data(0));
      check("a_acc_terms", at_a, r_cnt[0]);
      check("a_acc_ovf", ao_a, exp_ovf(0));
    end
    check("b_p_ready", pr_b, !pending[1]);
    check("b_acc_valid", av_b, pending[1]);
    if (pending[1]) begin
      check("b_acc_data", ad_b, exp_data(1));
      check("b_acc_terms", at_b, r_cnt[1]);
      check("b_acc_ovf", ao_b, exp_ovf(1));
    end
  endtask

  // Inputs change on the falling edge; outputs are checked on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge(0, pv_a, pd_a, pl_a, ar_a);
    model_edge(1, pv_b, pd_b, pl_b, ar_b);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic beat_a(int unsigned d, bit l);
    pv_a = 1'b1; pd_a = 8'(d); pl_a = l;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (took[0]) return;
    end
    check("a_beat_timeout_p_ready", pr_a, 1);
  endtask

  task automatic beat_b(int unsigned d, bit l);
    pv_b = 1'b1; pd_b = 8'(d); pl_b = l;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (took[1]) return;
    end
    check("b_beat_timeout_p_ready", pr_b, 1);
  endtask

  task automatic drain();
    pv_a = 0; pl_a = 0; ar_a = 1;
    pv_b = 0; pl_b = 0; ar_b = 1;
    cycle();
    cycle();
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_a_ready"}, pr_a, 0);
    check({tag, "_a_valid"}, av_a, 0);
    check({tag, "_a_data"},  ad_a, 0);
    check({tag, "_a_terms"}, at_a, 0);
    check({tag, "_a_ovf"},   ao_a, 0);
    check({tag, "_b_valid"}, av_b, 0);
    check({tag, "_b_data"},  ad_b, 0);
    check({tag, "_b_ovf"},   ao_b, 0);
  endtask

  initial begin
    reset = 1'b1;
    pv_a = 0; pd_a = 0; pl_a = 0; ar_a = 1;
    pv_b = 0; pd_b = 0; pl_b = 0; ar_b = 1;
    model_clear();
    #1;
    check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycle();

    // Full group of four back-to-back beats; result visible right after the 4th edge.
    for (int k = 0; k < 4; k++) beat_a(225, 0);
    check("t1_valid", av_a, 1);
    check("t1_data", ad_a, 900);
    check("t1_terms", at_a, 4);
    check("t1_ovf", ao_a, 0);
    drain();

    // Early close on p_last, then a fresh group starts from zero.
    beat_a(10, 0);
    beat_a(20, 1);
    check("t2_data", ad_a, 30);
    check("t2_terms", at_a, 2);
    pv_a = 0; pl_a = 0;
    cycle();
    beat_a(5, 1);
    check("t2_next_data", ad_a, 5);
    check("t2_next_terms", at_a, 1);
    drain();

    // Back-pressure: result held while a beat is waiting.
    ar_a = 0;
    beat_a(50, 1);
    pv_a = 1; pd_a = 7; pl_a = 0;
    repeat (5) cycle();
    check("t3_hold_ready", pr_a, 0);
    check("t3_hold_valid", av_a, 1);
    check("t3_hold_data", ad_a, 50);
    ar_a = 1;
    beat_a(7, 1);
    check("t3_after_data", ad_a, 7);
    check("t3_after_terms", at_a, 1);
    drain();

    // Idle gaps between beats do not advance the count.
    for (int k = 1; k <= 4; k++) begin
      beat_a(k, 0);
      if (k < 4) begin
        pv_a = 0;
        cycle();
        cycle();
      end
    end
    check("t4_data", ad_a, 10);
    check("t4_terms", at_a, 4);
    drain();

    // Narrow instance wraps and flags overflow for that group only.
    beat_b(200, 0);
    beat_b(100, 0);
    check("t5_data", ad_b, 44);
    check("t5_ovf", ao_b, 1);
    check("t5_terms", at_b, 2);
    pv_b = 0;
    cycle();
    beat_b(1, 0);
    beat_b(1, 0);
    check("t5_next_data", ad_b, 2);
    check("t5_next_ovf", ao_b, 0);
    drain();

    // Reset mid-group discards the partial sum immediately.
    beat_a(9, 0);
    beat_a(9, 0);
    pv_a = 0;
    reset = 1'b1;
    #1;
    check_reset_state("t6_reset");
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    cycle();
    for (int k = 0; k < 4; k++) beat_a(5, 0);
    check("t6_data", ad_a, 20);
    check("t6_terms", at_a, 4);
    drain();

    // Randomized traffic on both instances.
    for (int k = 0; k < 400; k++) begin
      pv_a = 1'($urandom_range(0, 1));
      pd_a = 8'($urandom_range(0, 255));
      pl_a = ($urandom_range(0, 5) == 0);
      ar_a = ($urandom_range(0, 2) != 0);
      pv_b = 1'($urandom_range(0, 1));
      pd_b = 8'($urandom_range(0, 255));
      pl_b = ($urandom_range(0, 5) == 0);
      ar_b = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
